// File: rtl/word_mem.sv
// word_mem: byte-addressed memory with big-endian word access at any byte
// address, delayed write commit and a zero-fill engine.
module word_mem #(
  parameter int ADDR_W       = 11,
  parameter int BPW          = 2,
  parameter int CLR_ON_RESET = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [BPW-1:0]    i_byte_en,
  input  logic [8*BPW-1:0]  i_data_in,
  input  logic              i_clr_req,
  output logic              o_ready,
  output logic [8*BPW-1:0]  o_data_out,
  output logic              o_rd_valid,
  output logic              o_busy
);

  localparam int WW    = 8 * BPW;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] BPW_W   = (ADDR_W+1)'(BPW);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0] r_mem [DEPTH];

  // Fill pointer carries one extra bit so the last partial word is detected
  // without wrapping back to byte 0.
  logic [ADDR_W:0] r_fill_ptr;
  logic            w_fill_last;

  // An accepted write is parked here for one cycle so that a read accepted
  // right behind it still sees the old bytes.
  logic              r_wr_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BPW-1:0]    r_wr_be;
  logic [WW-1:0]     r_wr_data;

  logic              w_accept;
  logic [WW-1:0]     w_rd_word;
  logic [ADDR_W-1:0] w_rd_lane_addr [BPW];
  logic [ADDR_W-1:0] w_wr_lane_addr [BPW];
  logic              w_wr_lane_en   [BPW];
  logic [7:0]        w_wr_lane_data [BPW];
  logic [ADDR_W:0]   w_fill_idx     [BPW];

  assign o_ready     = (r_state == ST_IDLE) && !i_clr_req;
  assign o_busy      = (r_state == ST_CLEAR);
  assign w_accept    = i_req && o_ready;
  assign w_fill_last = (r_fill_ptr + BPW_W) >= DEPTH_W;

  // Per-lane address/data decode; lane 0 is the most-significant byte.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign w_rd_lane_addr[gi] = i_address + ADDR_W'(gi);
    assign w_wr_lane_addr[gi] = r_wr_addr + ADDR_W'(gi);
    assign w_wr_lane_en[gi]   = r_wr_pend && r_wr_be[BPW-1-gi];
    assign w_wr_lane_data[gi] = r_wr_data[WW-1-8*gi -: 8];
    assign w_fill_idx[gi]     = r_fill_ptr + (ADDR_W+1)'(gi);
    assign w_rd_word[WW-1-8*gi -: 8] = r_mem[w_rd_lane_addr[gi]];
  end

  // Next-state logic: clear request in IDLE starts the fill, last fill word ends it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_clr_req) w_state_next = ST_CLEAR;
      ST_CLEAR: if (w_fill_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Memory array: commit the parked write, then the fill (fill wins on overlap).
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < BPW; k++) begin
      if (w_wr_lane_en[k]) begin
        r_mem[w_wr_lane_addr[k]] <= w_wr_lane_data[k];
      end
    end
    if (r_state == ST_CLEAR && !i_reset) begin
      for (int k = 0; k < BPW; k++) begin
        if (w_fill_idx[k] < DEPTH_W) begin
          r_mem[w_fill_idx[k][ADDR_W-1:0]] <= 8'h00;
        end
      end
    end
  end

  // Control state, fill pointer, write parking and registered read data.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_fill_ptr <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_be    <= '0;
      r_wr_data  <= '0;
      o_rd_valid <= 1'b0;
      o_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR && !w_fill_last) begin
        r_fill_ptr <= r_fill_ptr + BPW_W;
      end else begin
        r_fill_ptr <= '0;
      end
      r_wr_pend <= w_accept && i_wr_en;
      if (w_accept && i_wr_en) begin
        r_wr_addr <= i_address;
        r_wr_be   <= i_byte_en;
        r_wr_data <= i_data_in;
      end
      o_rd_valid <= w_accept && !i_wr_en;
      if (w_accept && !i_wr_en) begin
        o_data_out <= w_rd_word;
      end
    end
  end

endmodule

// File: tb/tb_word_mem.sv
// tb_word_mem: directed checks of word_mem at defaults (u0) and with BPW=4 (u1).
module tb_word_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance u0: defaults (ADDR_W=11, BPW=2)
  logic        a_reset = 1'b0, a_req = 1'b0, a_wr = 1'b0, a_clr = 1'b0;
  logic [10:0] a_addr = '0;
  logic [1:0]  a_be = '0;
  logic [15:0] a_din = '0;
  logic        a_ready, a_valid, a_busy;
  logic [15:0] a_dout;

  // Instance u1: BPW=4
  logic        b_reset = 1'b0, b_req = 1'b0, b_wr = 1'b0, b_clr = 1'b0;
  logic [10:0] b_addr = '0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_din = '0;
  logic        b_ready, b_valid, b_busy;
  logic [31:0] b_dout;

  int errors = 0;
  int checks = 0;

  word_mem u0 (
    .i_clock(clk), .i_reset(a_reset), .i_req(a_req), .i_wr_en(a_wr),
    .i_address(a_addr), .i_byte_en(a_be), .i_data_in(a_din), .i_clr_req(a_clr),
    .o_ready(a_ready), .o_data_out(a_dout), .o_rd_valid(a_valid), .o_busy(a_busy)
  );

  word_mem #(.ADDR_W(11), .BPW(4), .CLR_ON_RESET(1)) u1 (
    .i_clock(clk), .i_reset(b_reset), .i_req(b_req), .i_wr_en(b_wr),
    .i_address(b_addr), .i_byte_en(b_be), .i_data_in(b_din), .i_clr_req(b_clr),
    .o_ready(b_ready), .o_data_out(b_dout), .o_rd_valid(b_valid), .o_busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // u0 write: drive for one edge, then release
  task automatic a_write(input logic [10:0] addr, input logic [15:0] d, input logic [1:0] be);
    a_req = 1'b1; a_wr = 1'b1; a_addr = addr; a_din = d; a_be = be;
    tick();
    a_req = 1'b0; a_wr = 1'b0;
    $display("u0 wr addr=0x%03h data=0x%04h be=%b", addr, d, be);
  endtask

  // u0 read: after return, data_out/rd_valid belong to this read
  task automatic a_read(input logic [10:0] addr);
    a_req = 1'b1; a_wr = 1'b0; a_addr = addr;
    tick();
    a_req = 1'b0;
    $display("u0 rd addr=0x%03h data=0x%04h valid=%b", addr, a_dout, a_valid);
  endtask

  // Count cycles with busy high; bounded so a stuck engine cannot hang the run
  task automatic count_busy_a(output int n);
    n = 0;
    while (a_busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (b_busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    // Reset both instances for one cycle
    a_reset = 1'b1; b_reset = 1'b1;
    tick();
    a_reset = 1'b0; b_reset = 1'b0;
    chk("rst_busy",    {63'd0, a_busy},  64'd1);
    chk("rst_ready",   {63'd0, a_ready}, 64'd0);
    chk("rst_rdvalid", {63'd0, a_valid}, 64'd0);
    chk("rst_dout",    {48'd0, a_dout},  64'd0);

    count_busy_a(n);
    $display("u0 fill cycles=%0d", n);
    chk("fill_cycles_bpw2", n, 64'd1024);
    chk("ready_after_fill", {63'd0, a_ready}, 64'd1);

    a_read(11'h688);
    chk("rd688_cleared", {48'd0, a_dout}, 64'h0000);
    chk("rd688_valid",   {63'd0, a_valid}, 64'd1);

    a_write(11'h688, 16'h0005, 2'b11);
    chk("wr_no_valid", {63'd0, a_valid}, 64'd0);
    tick();
    a_read(11'h688);
    chk("rd688_0005", {48'd0, a_dout}, 64'h0005);
    a_read(11'h689);
    chk("rd689_0500", {48'd0, a_dout}, 64'h0500);

    // Partial byte enable: only LSB lane updated
    a_write(11'h010, 16'h1234, 2'b11);
    tick();
    a_write(11'h010, 16'hABCD, 2'b01);
    tick();
    a_read(11'h010);
    chk("rd010_12CD", {48'd0, a_dout}, 64'h12CD);

    // Word straddling the top of memory wraps to byte 0
    a_write(11'h7FF, 16'hBEEF, 2'b11);
    tick();
    a_read(11'h7FF);
    chk("rd7FF_BEEF", {48'd0, a_dout}, 64'hBEEF);
    a_read(11'h000);
    chk("rd000_EF00", {48'd0, a_dout}, 64'hEF00);

    // Read right behind a write sees old data; the next read sees new data
    a_write(11'h100, 16'h1111, 2'b11);
    a_req = 1'b1; a_wr = 1'b0; a_addr = 11'h100;
    tick();
    $display("u0 rd addr=0x100 data=0x%04h valid=%b", a_dout, a_valid);
    chk("rd_after_wr_old", {48'd0, a_dout}, 64'h0000);
    chk("rd_after_wr_vld", {63'd0, a_valid}, 64'd1);
    tick();
    a_req = 1'b0;
    $display("u0 rd addr=0x100 data=0x%04h valid=%b", a_dout, a_valid);
    chk("rd_after_wr_new", {48'd0, a_dout}, 64'h1111);
    tick();
    chk("hold_dout",   {48'd0, a_dout},  64'h1111);
    chk("idle_novalid", {63'd0, a_valid}, 64'd0);

    // Read accepted in the last IDLE cycle still completes while clear starts
    a_req = 1'b1; a_wr = 1'b0; a_addr = 11'h688;
    tick();
    a_req = 1'b0; a_clr = 1'b1;
    #1;
    chk("clr_ready_low", {63'd0, a_ready}, 64'd0);
    chk("last_rd_valid", {63'd0, a_valid}, 64'd1);
    chk("last_rd_data",  {48'd0, a_dout},  64'h0005);
    tick();
    a_clr = 1'b0;
    chk("clr_busy",        {63'd0, a_busy},  64'd1);
    chk("clr_rdvalid_low", {63'd0, a_valid}, 64'd0);
    count_busy_a(n);
    $display("u0 clear cycles=%0d", n);
    chk("clear_cycles_bpw2", n, 64'd1024);
    a_read(11'h688);
    chk("rd688_after_clr", {48'd0, a_dout}, 64'h0000);
    a_read(11'h7FF);
    chk("rd7FF_after_clr", {48'd0, a_dout}, 64'h0000);

    // ---- BPW = 4 instance ----
    chk("b_ready_idle", {63'd0, b_ready}, 64'd1);
    b_req = 1'b1; b_wr = 1'b1; b_addr = 11'h020; b_din = 32'hDEADBEEF; b_be = 4'hF;
    tick();
    b_req = 1'b0; b_wr = 1'b0;
    $display("u1 wr addr=0x020 data=0xDEADBEEF be=1111");
    tick();
    b_req = 1'b1; b_addr = 11'h021;
    tick();
    b_req = 1'b0;
    $display("u1 rd addr=0x021 data=0x%08h valid=%b", b_dout, b_valid);
    chk("b_rd021", {32'd0, b_dout}, 64'hADBEEF00);

    // Request coincident with clr_req is dropped
    b_req = 1'b1; b_wr = 1'b0; b_addr = 11'h020; b_clr = 1'b1;
    #1;
    chk("b_clr_ready_low", {63'd0, b_ready}, 64'd0);
    tick();
    b_req = 1'b0; b_clr = 1'b0;
    chk("b_dropped_novalid", {63'd0, b_valid}, 64'd0);
    chk("b_clr_busy",        {63'd0, b_busy},  64'd1);

    // Reset at fill cycle 100 restarts the fill
    for (int i = 0; i < 100; i++) tick();
    chk("b_busy_at_100", {63'd0, b_busy}, 64'd1);
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    count_busy_b(n);
    $display("u1 fill cycles after reset=%0d", n);
    chk("fill_cycles_bpw4", n, 64'd512);
    b_req = 1'b1; b_addr = 11'h020;
    tick();
    b_req = 1'b0;
    $display("u1 rd addr=0x020 data=0x%08h valid=%b", b_dout, b_valid);
    chk("b_rd020_cleared", {32'd0, b_dout}, 64'h0);
    chk("b_rd020_valid",   {63'd0, b_valid}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
